// File: rtl/phys_free_list.sv
// Physical register free list with retirement RAT.
// Free registers live in a 32-entry circular list. The region [commit_ptr, alloc_ptr)
// holds speculative allocations, so a flush rewinds alloc_ptr to commit_ptr to re-issue
// them in their original order. free_count is authoritative; pointers never imply full/empty.
module phys_free_list #(
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned NUM_PHYS_REGS = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       alloc_req,
  output logic       alloc_valid,
  output logic [5:0] alloc_preg,
  input  logic       commit_valid,
  input  logic [4:0] commit_arch,
  input  logic [5:0] commit_preg,
  input  logic       flush,
  input  logic [4:0] rrat_rd_arch,
  output logic [5:0] rrat_rd_preg,
  output logic [5:0] free_count,
  output logic       proto_err
);

  localparam int unsigned FreeDepth = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam logic [5:0]  FreeFull  = 6'(FreeDepth);

  logic [5:0] list_q [32];
  logic [5:0] list_d [32];
  logic [5:0] rrat_q [32];
  logic [5:0] rrat_d [32];
  logic [4:0] alloc_ptr_q, alloc_ptr_d;
  logic [4:0] commit_ptr_q, commit_ptr_d;
  logic [4:0] release_ptr_q, release_ptr_d;
  logic [5:0] free_count_q, free_count_d;
  logic [5:0] inflight_q, inflight_d;
  logic       proto_err_q, proto_err_d;

  logic alloc_fire;
  logic commit_fire;
  logic commit_bad;

  // Event decode; commits to $zero are dropped before anything else looks at them.
  always_comb begin
    alloc_fire  = alloc_req && (free_count_q != 6'd0) && !flush;
    commit_fire = commit_valid && (commit_arch != 5'd0) && (inflight_q != 6'd0);
    commit_bad  = commit_valid && (commit_arch != 5'd0) && (inflight_q == 6'd0);
  end

  // Next-state: commit is applied first so a same-cycle flush rewinds to the post-commit point.
  always_comb begin
    list_d        = list_q;
    rrat_d        = rrat_q;
    alloc_ptr_d   = alloc_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    release_ptr_d = release_ptr_q;
    free_count_d  = free_count_q;
    inflight_d    = inflight_q;
    proto_err_d   = proto_err_q || commit_bad;

    if (commit_fire) begin
      // The old architectural mapping becomes free; the new one becomes architectural.
      list_d[release_ptr_q] = rrat_q[commit_arch];
      rrat_d[commit_arch]   = commit_preg;
      release_ptr_d         = release_ptr_q + 5'd1;
      commit_ptr_d          = commit_ptr_q + 5'd1;
    end

    if (alloc_fire) begin
      alloc_ptr_d = alloc_ptr_q + 5'd1;
    end

    case ({alloc_fire, commit_fire})
      2'b10: begin
        free_count_d = free_count_q - 6'd1;
        inflight_d   = inflight_q + 6'd1;
      end
      2'b01: begin
        free_count_d = free_count_q + 6'd1;
        inflight_d   = inflight_q - 6'd1;
      end
      default: ;
    endcase

    if (flush) begin
      alloc_ptr_d  = commit_ptr_d;
      free_count_d = FreeFull;
      inflight_d   = 6'd0;
    end
  end

  // State register; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        rrat_q[i] <= 6'(i);
        list_q[i] <= 6'(32 + i);
      end
      alloc_ptr_q   <= 5'd0;
      commit_ptr_q  <= 5'd0;
      release_ptr_q <= 5'd0;
      free_count_q  <= FreeFull;
      inflight_q    <= 6'd0;
      proto_err_q   <= 1'b0;
    end else begin
      list_q        <= list_d;
      rrat_q        <= rrat_d;
      alloc_ptr_q   <= alloc_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      release_ptr_q <= release_ptr_d;
      free_count_q  <= free_count_d;
      inflight_q    <= inflight_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // Outputs read registered state only, so releases and RRAT writes show up next cycle.
  always_comb begin
    alloc_valid  = (free_count_q != 6'd0);
    alloc_preg   = list_q[alloc_ptr_q];
    rrat_rd_preg = rrat_q[rrat_rd_arch];
    free_count   = free_count_q;
    proto_err    = proto_err_q;
  end

endmodule
